dmem_store_buffer: RTL and testbench



---
 rtl/dmem_store_buffer.sv | 125 ++++++++++++
 tb/tb_dmem_store_buffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer: circular FIFO of byte-enabled double-word stores with
// newest-entry coalescing, request/grant drain and load forwarding.
module dmem_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 13
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_be,
    input  logic [63:0]                  in_data,
    input  logic [AW-1:0]                in_addr,
    output logic                         mem_req,
    input  logic                         mem_gnt,
    output logic [7:0]                   mem_be,
    output logic [63:0]                  mem_data,
    output logic [AW-1:0]                mem_addr,
    input  logic [AW-1:0]                ld_addr,
    output logic [7:0]                   ld_be,
    output logic [63:0]                  ld_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [7:0]    be_q   [DEPTH];
    logic [63:0]   data_q [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] newest_idx;
    logic          full;
    logic          push_req;
    logic          coalesce;
    logic          alloc;
    logic          pop;

    assign newest_idx = tail_q - PW'(1);
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign in_ready   = !full;
    assign mem_req    = !empty;

    assign push_req = in_valid && !full && (in_be != '0);
    // Never merge into the head: with count>=2 the newest entry is not the head.
    assign coalesce = push_req && (count_q >= CW'(2)) && (addr_q[newest_idx] == in_addr);
    assign alloc    = push_req && !coalesce;
    assign pop      = !empty && mem_gnt;

    assign mem_be   = empty ? '0 : be_q[head_q];
    assign mem_data = empty ? '0 : data_q[head_q];
    assign mem_addr = empty ? '0 : addr_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (alloc) begin
            tail_d = tail_q + PW'(1);
        end
        if (alloc && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!alloc && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            be_q[tail_q]   <= in_be;
            data_q[tail_q] <= in_data;
            addr_q[tail_q] <= in_addr;
        end else if (coalesce) begin
            be_q[newest_idx] <= be_q[newest_idx] | in_be;
            for (int unsigned b = 0; b < 8; b++) begin
                if (in_be[b]) begin
                    data_q[newest_idx][b*8 +: 8] <= in_data[b*8 +: 8];
                end
            end
        end
    end

    // Walk oldest to youngest so younger matching bytes win each lane.
    logic [PW-1:0] fwd_idx;

    always_comb begin
        ld_be   = '0;
        ld_data = '0;
        fwd_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[fwd_idx] == ld_addr)) begin
                for (int unsigned b = 0; b < 8; b++) begin
                    if (be_q[fwd_idx][b]) begin
                        ld_be[b]           = 1'b1;
                        ld_data[b*8 +: 8]  = data_q[fwd_idx][b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: vector table plus hand sequences for
// mid-stream reset and streaming push/pop across pointer wrap.
module tb_dmem_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_be;
    logic [63:0] in_data;
    logic [12:0] in_addr;
    logic        mem_req;
    logic        mem_gnt;
    logic [7:0]  mem_be;
    logic [63:0] mem_data;
    logic [12:0] mem_addr;
    logic [12:0] ld_addr;
    logic [7:0]  ld_be;
    logic [63:0] ld_data;
    logic [2:0]  count;
    logic        empty;

    int checks;
    int failures;

    dmem_store_buffer #(.DEPTH(4), .AW(13)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_be    (in_be),
        .in_data  (in_data),
        .in_addr  (in_addr),
        .mem_req  (mem_req),
        .mem_gnt  (mem_gnt),
        .mem_be   (mem_be),
        .mem_data (mem_data),
        .mem_addr (mem_addr),
        .ld_addr  (ld_addr),
        .ld_be    (ld_be),
        .ld_data  (ld_data),
        .count    (count),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v;
        logic [7:0]  be;
        logic [63:0] d;
        logic [12:0] a;
        logic        g;
        logic [12:0] la;
        logic [2:0]  cnt;
        logic        rdy;
        logic        req;
        logic [12:0] ma;
        logic [7:0]  mbe;
        logic [63:0] md;
        logic [7:0]  lbe;
        logic [63:0] ld;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic v, input logic [7:0] be, input logic [63:0] d, input logic [12:0] a,
        input logic g, input logic [12:0] la,
        input logic [2:0] cnt, input logic rdy, input logic req, input logic [12:0] ma,
        input logic [7:0] mbe, input logic [63:0] md, input logic [7:0] lbe, input logic [63:0] ld);
        vec_t r;
        r.v = v; r.be = be; r.d = d; r.a = a; r.g = g; r.la = la;
        r.cnt = cnt; r.rdy = rdy; r.req = req; r.ma = ma; r.mbe = mbe; r.md = md;
        r.lbe = lbe; r.ld = ld;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] R01 = {8{8'h01}};
    localparam logic [63:0] R02 = {8{8'h02}};
    localparam logic [63:0] R03 = {8{8'h03}};
    localparam logic [63:0] R04 = {8{8'h04}};
    localparam logic [63:0] R06 = {8{8'h06}};
    localparam logic [63:0] R11 = {8{8'h11}};
    localparam logic [63:0] R33 = {8{8'h33}};
    localparam logic [63:0] R77 = {8{8'h77}};
    localparam logic [63:0] F9  = 64'h22222222_00000000;

    logic [12:0] order[$];
    int          popped;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_be    = '0;
        in_data  = '0;
        in_addr  = '0;
        mem_gnt  = 1'b0;
        ld_addr  = '0;

        // v  be     data                     a   g  la  | cnt rdy req ma  mbe    md                       lbe    ld
        vecs.push_back(mk(1, 8'h0F, 64'h11223344, 5, 0, 5,   1, 1, 1, 5, 8'h0F, 64'h11223344, 8'h0F, 64'h11223344));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 5,   0, 1, 0, 0, 8'h00, 64'h0,        8'h00, 64'h0));
        vecs.push_back(mk(1, 8'hFF, R01,          1, 0, 1,   1, 1, 1, 1, 8'hFF, R01,          8'hFF, R01));
        vecs.push_back(mk(1, 8'hFF, R02,          2, 0, 2,   2, 1, 1, 1, 8'hFF, R01,          8'hFF, R02));
        vecs.push_back(mk(1, 8'hFF, R03,          3, 0, 3,   3, 1, 1, 1, 8'hFF, R01,          8'hFF, R03));
        vecs.push_back(mk(1, 8'hFF, R04,          4, 0, 4,   4, 0, 1, 1, 8'hFF, R01,          8'hFF, R04));
        vecs.push_back(mk(1, 8'hFF, R06,          6, 0, 6,   4, 0, 1, 1, 8'hFF, R01,          8'h00, 64'h0));
        vecs.push_back(mk(1, 8'hFF, R06,          6, 1, 6,   3, 1, 1, 2, 8'hFF, R02,          8'h00, 64'h0));
        vecs.push_back(mk(1, 8'hFF, R06,          6, 0, 6,   4, 0, 1, 2, 8'hFF, R02,          8'hFF, R06));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 6,   3, 1, 1, 3, 8'hFF, R03,          8'hFF, R06));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 6,   2, 1, 1, 4, 8'hFF, R04,          8'hFF, R06));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 6,   1, 1, 1, 6, 8'hFF, R06,          8'hFF, R06));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 6,   0, 1, 0, 0, 8'h00, 64'h0,        8'h00, 64'h0));
        vecs.push_back(mk(1, 8'h01, 64'h01,       1, 0, 1,   1, 1, 1, 1, 8'h01, 64'h01,       8'h01, 64'h01));
        vecs.push_back(mk(1, 8'h02, 64'h5500,     1, 0, 1,   2, 1, 1, 1, 8'h01, 64'h01,       8'h03, 64'h5501));
        vecs.push_back(mk(1, 8'h01, 64'hAA,       7, 0, 7,   3, 1, 1, 1, 8'h01, 64'h01,       8'h01, 64'hAA));
        vecs.push_back(mk(1, 8'h02, 64'hBB00,     7, 0, 7,   3, 1, 1, 1, 8'h01, 64'h01,       8'h03, 64'hBBAA));
        vecs.push_back(mk(1, 8'h04, 64'hCC0000,   1, 0, 1,   4, 0, 1, 1, 8'h01, 64'h01,       8'h07, 64'hCC5501));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 7,   3, 1, 1, 1, 8'h02, 64'h5500,     8'h03, 64'hBBAA));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 7,   2, 1, 1, 7, 8'h03, 64'hBBAA,     8'h03, 64'hBBAA));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 1,   1, 1, 1, 1, 8'h04, 64'hCC0000,   8'h04, 64'hCC0000));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 1,   0, 1, 0, 0, 8'h00, 64'h0,        8'h00, 64'h0));
        vecs.push_back(mk(1, 8'hFF, R11,          9, 0, 9,   1, 1, 1, 9, 8'hFF, R11,          8'hFF, R11));
        vecs.push_back(mk(1, 8'hFF, R33,          3, 0, 9,   2, 1, 1, 9, 8'hFF, R11,          8'hFF, R11));
        vecs.push_back(mk(1, 8'hF0, F9,           9, 0, 9,   3, 1, 1, 9, 8'hFF, R11,          8'hFF, 64'h22222222_11111111));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 0, 8,   3, 1, 1, 9, 8'hFF, R11,          8'h00, 64'h0));
        vecs.push_back(mk(1, 8'h00, 64'hDEAD,     9, 0, 3,   3, 1, 1, 9, 8'hFF, R11,          8'hFF, R33));
        vecs.push_back(mk(1, 8'h00, R77,          9, 0, 9,   3, 1, 1, 9, 8'hFF, R11,          8'hFF, 64'h22222222_11111111));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 9,   2, 1, 1, 3, 8'hFF, R33,          8'hF0, F9));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 9,   1, 1, 1, 9, 8'hF0, F9,           8'hF0, F9));
        vecs.push_back(mk(0, 8'h00, 64'h0,        0, 1, 9,   0, 1, 0, 0, 8'h00, 64'h0,        8'h00, 64'h0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_membe", 64'(mem_be), 64'd0);
        chk("rst_memdata", mem_data, 64'd0);
        chk("rst_memaddr", 64'(mem_addr), 64'd0);
        chk("rst_ldbe", 64'(ld_be), 64'd0);
        chk("rst_lddata", ld_data, 64'd0);
        rst_n = 1'b1;

        // Mid-stream reset with a grant pending discards everything
        step();
        in_valid = 1'b1; in_be = 8'hFF; in_data = 64'h20; in_addr = 13'd20; ld_addr = 13'd20;
        step();
        in_addr = 13'd21; in_data = 64'h21;
        step();
        in_valid = 1'b0; in_be = '0;
        chk("pre_rst_count", 64'(count), 64'd2);
        mem_gnt = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_req", 64'(mem_req), 64'd0);
        chk("midrst_ldbe", 64'(ld_be), 64'd0);
        step();
        chk("midrst_hold_count", 64'(count), 64'd0);
        #2;
        rst_n = 1'b1;
        mem_gnt = 1'b0;
        step();

        foreach (vecs[i]) begin
            in_valid = vecs[i].v;
            in_be    = vecs[i].be;
            in_data  = vecs[i].d;
            in_addr  = vecs[i].a;
            mem_gnt  = vecs[i].g;
            ld_addr  = vecs[i].la;
            step();
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].cnt == 3'd0));
            chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
            chk($sformatf("v%0d_req", i), 64'(mem_req), 64'(vecs[i].req));
            chk($sformatf("v%0d_maddr", i), 64'(mem_addr), 64'(vecs[i].ma));
            chk($sformatf("v%0d_mbe", i), 64'(mem_be), 64'(vecs[i].mbe));
            chk($sformatf("v%0d_mdata", i), mem_data, vecs[i].md);
            chk($sformatf("v%0d_ldbe", i), 64'(ld_be), 64'(vecs[i].lbe));
            chk($sformatf("v%0d_lddata", i), ld_data, vecs[i].ld);
        end

        // Streaming push+pop at count=2 across pointer wrap
        in_valid = 1'b1; in_be = 8'hFF; mem_gnt = 1'b0;
        in_addr = 13'd40; in_data = 64'd40;
        step();
        order.push_back(13'd40);
        in_addr = 13'd41; in_data = 64'd41;
        step();
        order.push_back(13'd41);
        chk("strm_fill_count", 64'(count), 64'd2);
        popped = 0;
        mem_gnt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_addr = 13'(50 + k);
            in_data = 64'(50 + k);
            step();
            order.push_back(13'(50 + k));
            popped++;
            chk($sformatf("strm%0d_count", k), 64'(count), 64'd2);
            chk($sformatf("strm%0d_ready", k), 64'(in_ready), 64'd1);
            chk($sformatf("strm%0d_maddr", k), 64'(mem_addr), 64'(order[popped]));
            chk($sformatf("strm%0d_mdata", k), mem_data, 64'(order[popped]));
        end
        in_valid = 1'b0; in_be = '0;
        while (popped < order.size()) begin
            step();
            popped++;
            chk($sformatf("drain%0d_count", popped), 64'(count), 64'(order.size() - popped));
            if (popped < order.size())
                chk($sformatf("drain%0d_maddr", popped), 64'(mem_addr), 64'(order[popped]));
        end
        chk("final_empty", 64'(empty), 64'd1);
        chk("final_req", 64'(mem_req), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
